// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared fixed-point widths and divider state encoding
package fixed_point_pkg;

   localparam int INT_W_DEF  = 8;
   localparam int FRAC_W_DEF = 8;
   localparam int W_DEF      = INT_W_DEF + FRAC_W_DEF;
   localparam int N_DEF      = W_DEF + FRAC_W_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/fixed_div_step.sv
// rtl/fixed_div_step.sv - one restoring-division compare/subtract step
module fixed_div_step #(
   parameter int W = 16
) (
   input  logic [W:0]   rem_shift,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic         qbit
);

   assign qbit = (rem_shift >= {1'b0, divisor});

   // The true difference is below divisor, so W-bit modular subtraction is exact.
   assign rem_next = qbit ? (rem_shift[W-1:0] - divisor) : rem_shift[W-1:0];

endmodule

// File: rtl/fixed_divider.sv
// rtl/fixed_divider.sv - sequential unsigned fixed-point divider, optional rounding via FIXED_DIV_ROUND_EN
module fixed_divider
   import fixed_point_pkg::*;
#(
   parameter int INT_W  = INT_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [INT_W+FRAC_W-1:0] num1,
   input  logic [INT_W+FRAC_W-1:0] num2,
   output logic                    busy,
   output logic                    done,
   output logic [INT_W+FRAC_W-1:0] result,
   output logic                    overflow,
   output logic                    div_zero
);

   localparam int W = INT_W + FRAC_W;
   localparam int N = W + FRAC_W;
`ifdef FIXED_DIV_ROUND_EN
   localparam int ITER = N + 1;
`else
   localparam int ITER = N;
`endif
   localparam int CW = $clog2(ITER);

   div_state_t       state;
   logic [ITER-1:0]  num_sh;
   logic [W-1:0]     div;
   logic [W-1:0]     rem;
   logic [ITER-2:0]  quo;
   logic [CW-1:0]    cnt;

   logic [W:0]       rem_shift;
   logic [W-1:0]     rem_next;
   logic             qbit;
   logic [ITER-1:0]  quo_next;
   logic [N-1:0]     q_int;
   logic             guard;
   logic [W:0]       rounded;

   assign rem_shift = {rem, num_sh[ITER-1]};
   assign quo_next  = {quo, qbit};

`ifdef FIXED_DIV_ROUND_EN
   assign q_int = quo_next[ITER-1:1];
   assign guard = quo_next[0];
`else
   assign q_int = quo_next;
   assign guard = 1'b0;
`endif

   assign rounded = {1'b0, q_int[W-1:0]} + {{W{1'b0}}, guard};

   fixed_div_step #(.W(W)) u_step (
      .rem_shift (rem_shift),
      .divisor   (div),
      .rem_next  (rem_next),
      .qbit      (qbit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         num_sh   <= '0;
         div      <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (num2 == '0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     result   <= '1;
                     overflow <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     state  <= CALC;
                     busy   <= 1'b1;
                     num_sh <= {num1, {(ITER-W){1'b0}}};
                     div    <= num2;
                     rem    <= '0;
                     quo    <= '0;
                     cnt    <= CW'(ITER-1);
                  end
               end
            end
            CALC: begin
               num_sh <= num_sh << 1;
               rem    <= rem_next;
               quo    <= quo_next[ITER-2:0];
               cnt    <= cnt - 1'b1;
               // Final bit: results are taken from the next-state quotient so they line up with done.
               if (cnt == '0) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  result   <= rounded[W-1:0];
                  overflow <= (|q_int[N-1:W]) | rounded[W];
                  div_zero <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_divider.sv
// tb/tb_fixed_divider.sv - directed table-driven bench for fixed_divider
module tb_fixed_divider;

`ifdef FIXED_DIV_ROUND_EN
   localparam bit ROUND   = 1'b1;
   localparam int EXP_LAT = 25;
`else
   localparam bit ROUND   = 1'b0;
   localparam int EXP_LAT = 24;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num1;
   logic [15:0] num2;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        overflow;
   logic        div_zero;

   int checks;
   int errors;

   typedef struct {
      logic [15:0] n1;
      logic [15:0] n2;
      logic [15:0] res_t;
      logic        ov_t;
      logic [15:0] res_r;
      logic        ov_r;
      logic        dz;
   } vec_t;

   vec_t vecs[14];

   fixed_divider u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .num1     (num1),
      .num2     (num2),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic do_div(input logic [15:0] n1, input logic [15:0] n2, input logic [15:0] er,
                         input logic eo, input logic ed, input int el, input string nm);
      int lat;
      bit busy_ok;
      @(negedge clk);
      num1  = n1;
      num2  = n2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      num1  = ~n1;
      num2  = 16'h0000;
      lat     = -1;
      busy_ok = 1'b1;
      for (int c = 0; c < 60 && lat < 0; c++) begin
         @(negedge clk);
         if (done) lat = c;
         else if (!busy) busy_ok = 1'b0;
      end
      chk({nm, " latency"}, 32'(lat), 32'(el));
      chk({nm, " busy_during_calc"}, 32'(busy_ok), 32'd1);
      if (lat >= 0) begin
         chk({nm, " result"}, 32'(result), 32'(er));
         chk({nm, " overflow"}, 32'(overflow), 32'(eo));
         chk({nm, " div_zero"}, 32'(div_zero), 32'(ed));
         chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
         @(negedge clk);
         chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
         chk({nm, " result_hold"}, 32'(result), 32'(er));
      end
   endtask

   initial begin
      int pulses;
      int lat;
      logic [15:0] first_res;
      checks = 0;
      errors = 0;

      vecs[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 16'h0180, 1'b0, 1'b0};
      vecs[1]  = '{16'h0200, 16'h0300, 16'h00AA, 1'b0, 16'h00AB, 1'b0, 1'b0};
      vecs[2]  = '{16'hFF00, 16'h0080, 16'hFE00, 1'b1, 16'hFE00, 1'b1, 1'b0};
      vecs[3]  = '{16'h1234, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1};
      vecs[4]  = '{16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[5]  = '{16'hFFFF, 16'h0001, 16'hFF00, 1'b1, 16'hFF00, 1'b1, 1'b0};
      vecs[6]  = '{16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{16'h0080, 16'h0100, 16'h0080, 1'b0, 16'h0080, 1'b0, 1'b0};
      vecs[8]  = '{16'h0A00, 16'h0300, 16'h0355, 1'b0, 16'h0355, 1'b0, 1'b0};
      vecs[9]  = '{16'h0001, 16'h0003, 16'h0055, 1'b0, 16'h0055, 1'b0, 1'b0};
      vecs[10] = '{16'h0002, 16'h0003, 16'h00AA, 1'b0, 16'h00AB, 1'b0, 1'b0};
      vecs[11] = '{16'h0000, 16'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[12] = '{16'h7FFF, 16'h0001, 16'hFF00, 1'b1, 16'hFF00, 1'b1, 1'b0};
      vecs[13] = '{16'h0005, 16'h0002, 16'h0280, 1'b0, 16'h0280, 1'b0, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      num1  = 16'h0000;
      num2  = 16'h0000;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", 32'(result), 32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset div_zero", 32'(div_zero), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         do_div(vecs[i].n1, vecs[i].n2,
                ROUND ? vecs[i].res_r : vecs[i].res_t,
                ROUND ? vecs[i].ov_r : vecs[i].ov_t,
                vecs[i].dz, vecs[i].dz ? 0 : EXP_LAT, $sformatf("vec%0d", i));
      end

      // Second start while busy must be dropped; a start right after done is taken.
      @(negedge clk);
      num1  = 16'h0300;
      num2  = 16'h0200;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      num1  = 16'h0100;
      num2  = 16'h0100;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      pulses    = 0;
      lat       = -1;
      first_res = 16'h0000;
      for (int c = 0; c < 60 && lat < 0; c++) begin
         @(negedge clk);
         if (done) begin
            lat       = c;
            pulses++;
            first_res = result;
         end
      end
      chk("busy_start first_done_seen", 32'(lat >= 0), 32'd1);
      chk("busy_start result", 32'(first_res), 32'h0180);
      do_div(16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, EXP_LAT, "after_done");
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("busy_start single_done", 32'(pulses), 32'd1);

      // Start presented only during the DONE cycle is ignored.
      @(negedge clk);
      num1  = 16'h0300;
      num2  = 16'h0200;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int c = 0; c < 60 && lat < 0; c++) begin
         @(negedge clk);
         if (done) lat = c;
      end
      chk("done_start latency", 32'(lat), 32'(EXP_LAT));
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("done_start ignored", 32'(pulses), 32'd0);

      // Asynchronous reset in the middle of a calculation.
      @(negedge clk);
      num1  = 16'h0A00;
      num2  = 16'h0300;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      chk("midreset busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset done", 32'(done), 32'd0);
      chk("midreset result", 32'(result), 32'd0);
      chk("midreset overflow", 32'(overflow), 32'd0);
      chk("midreset div_zero", 32'(div_zero), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("midreset no_done", 32'(pulses), 32'd0);
      do_div(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, EXP_LAT, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
